fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains FFT sample words from the FIFO read side and sends
// them to the microcontroller over UART 8N1, one header byte then
// FRAME_WORDS words per frame, each word as two bytes, MSB first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line idle, waiting for a registered rising edge of uart_en
// HDR     | shifting out the HEADER sync byte
// FETCH   | pop one word when the FIFO is not empty, else stall (line high)
// WAIT    | FIFO read latency cycle, capture fifo_dout into the hold register
// SEND_HI | shifting out zero-extended fifo_dout[DATA_W-1:8]
// SEND_LO | shifting out fifo_dout[7:0], then next word / abort / done
// DONE    | one-cycle frame_done pulse
module fifo_uart_tx #(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int          DATA_W       = 14,
    parameter int          FRAME_WORDS  = 1024,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              uart_txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam logic [BCW-1:0] BAUD_LOAD = BCW'(CLKS_PER_BIT - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, WAIT, SEND_HI, SEND_LO, DONE
    } state_t;

    state_t         state, state_nxt;
    logic           en_q, en_rise_q;
    logic [BCW-1:0] baud_cnt;
    logic [3:0]     bit_idx;
    logic [WCW-1:0] word_cnt;
    logic [15:0]    hold;
    logic           sending, bit_end, byte_end;
    logic [7:0]     tx_byte;
    logic [9:0]     tx_frame;

    assign sending  = (state == HDR) || (state == SEND_HI) || (state == SEND_LO);
    assign bit_end  = (baud_cnt == '0);
    assign byte_end = sending && bit_end && (bit_idx == 4'd9);

    // Registered edge detect: a level held high never retriggers a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            en_rise_q <= 1'b0;
        end else begin
            en_q      <= uart_en;
            en_rise_q <= uart_en & ~en_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobe outputs; abort is only honoured at byte boundaries.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        case (state)
            IDLE:    if (en_rise_q) state_nxt = HDR;
            HDR:     if (byte_end) state_nxt = uart_en ? FETCH : IDLE;
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT:    state_nxt = SEND_HI;
            SEND_HI: if (byte_end) state_nxt = SEND_LO;
            SEND_LO: begin
                if (byte_end) begin
                    if (word_cnt == LAST_WORD) state_nxt = DONE;
                    else if (!uart_en)         state_nxt = IDLE;
                    else                       state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing: baud down-counter plus bit index, rearmed outside send states
    // so the next byte starts on the cycle right after the previous stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
        end else if (!sending) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= 4'd0;
        end else if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
        end else begin
            baud_cnt <= baud_cnt - BCW'(1);
        end
    end

    // Word counter and capture of the popped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            hold     <= '0;
        end else begin
            if (state == IDLE || state == DONE)
                word_cnt <= '0;
            else if (state == SEND_LO && byte_end)
                word_cnt <= word_cnt + WCW'(1);
            if (state == WAIT)
                hold <= 16'(fifo_dout);
        end
    end

    // Line driver: combinational from state so reset forces the line high at once.
    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            HDR:     tx_byte = HEADER;
            SEND_HI: tx_byte = hold[15:8];
            SEND_LO: tx_byte = hold[7:0];
            default: tx_byte = 8'hFF;
        endcase
        tx_frame = {1'b1, tx_byte, 1'b0};
        uart_txd = sending ? tx_frame[bit_idx] : 1'b1;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, UART line decoder and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int FW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [13:0] fifo_dout = '0;
    logic        fifo_rd_en, uart_txd, busy, frame_done;

    fifo_uart_tx #(
        .CLK_FREQ(16), .BAUD(4), .DATA_W(14), .FRAME_WORDS(FW), .HEADER(8'hAA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_en(uart_en), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .uart_txd(uart_txd),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [13:0] fq[$];
    logic [7:0]  exp_q[$];
    int          starts[$];
    int cyc = 0, rd_cnt = 0, rd_bad = 0, nbytes = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;

    always @(posedge clk) cyc++;

    // FIFO model: one cycle read latency, writes visible after the next edge.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt++;
            if (fifo_empty) rd_bad++;
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Line decoder: every cycle of every bit is sampled, so a bit of the
    // wrong length shows up as a bit-timing error or a wrong byte.
    int         mc = -1;
    int         st = 0;
    logic [7:0] sh = '0;
    logic       bit_first = 1'b0;
    logic       bad = 1'b0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst_n) begin
            mc = -1;
        end else if (mc < 0) begin
            if (!uart_txd) begin
                mc = 1; bad = 1'b0; bit_first = 1'b0; st = cyc;
            end
        end else begin
            if (mc % CPB == 0) begin
                bit_first = uart_txd;
                if (mc / CPB >= 1 && mc / CPB <= 8) sh[mc / CPB - 1] = uart_txd;
                if (mc / CPB == 9 && !uart_txd) bad = 1'b1;
            end else if (uart_txd != bit_first) begin
                bad = 1'b1;
            end
            mc++;
            if (mc == 10 * CPB) begin
                check("bit_timing", 32'(bad), 32'd0);
                if (exp_q.size() == 0) check("unexpected_byte", 32'(sh), 32'h100);
                else                   check("byte", 32'(sh), 32'(exp_q.pop_front()));
                starts.push_back(st);
                nbytes++;
                mc = -1;
            end
        end
    end

    task automatic exp_word(input logic [13:0] w);
        exp_q.push_back({2'b00, w[13:8]});
        exp_q.push_back(w[7:0]);
    endtask

    task automatic wait_bytes(input int n, input int lim);
        int k = 0;
        while (nbytes < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("wait_bytes_timeout", 32'(nbytes >= n), 32'd1);
    endtask

    // Runs one full frame of the given words and checks its framing figures.
    task automatic full_frame(input string tag, input logic [13:0] w0, input logic [13:0] w1,
                              input logic [13:0] w2, input logic [13:0] w3);
        int b0, rd0, bz0, d0, rc;
        exp_q.push_back(8'hAA);
        exp_word(w0); exp_word(w1); exp_word(w2); exp_word(w3);
        fq.push_back(w0); fq.push_back(w1); fq.push_back(w2); fq.push_back(w3);
        repeat (3) @(negedge clk);
        b0 = nbytes; rd0 = rd_cnt; bz0 = busy_cnt; d0 = done_cnt;
        uart_en = 1'b1;
        rc = cyc;
        wait_bytes(b0 + 9, 2000);
        repeat (3) @(negedge clk);
        check({tag, "_latency"}, 32'(starts[b0] - rc), 32'd2);
        check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'd4);
        check({tag, "_frame_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_done_pos"}, 32'(done_cyc - starts[b0 + 8]), 32'(10 * CPB));
        check({tag, "_busy_cycles"}, 32'(busy_cnt - bz0), 32'(9 * 10 * CPB + 2 * FW + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, rd0, d0, hi;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        full_frame("basic", 14'h3ABC, 14'h0001, 14'h2000, 14'h1FFF);

        // Level held high after the frame must not start another one.
        b = nbytes;
        repeat (200) @(negedge clk);
        check("hold_no_retrigger", 32'(nbytes - b), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);
        uart_en = 1'b0;
        full_frame("retrig", 14'h3FFF, 14'h0000, 14'h1234, 14'h0ABC);

        // Underflow stall after two words.
        uart_en = 1'b0;
        repeat (3) @(negedge clk);
        b = nbytes; rd0 = rd_cnt; d0 = done_cnt;
        exp_q.push_back(8'hAA);
        exp_word(14'h1111); exp_word(14'h2222); exp_word(14'h3333); exp_word(14'h0444);
        fq.push_back(14'h1111); fq.push_back(14'h2222);
        repeat (3) @(negedge clk);
        uart_en = 1'b1;
        wait_bytes(b + 5, 2000);
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd) hi++;
        end
        check("stall_txd_high", 32'(hi), 32'd100);
        check("stall_rd_pulses", 32'(rd_cnt - rd0), 32'd2);
        check("stall_busy", 32'(busy), 32'd1);
        fq.push_back(14'h3333); fq.push_back(14'h0444);
        wait_bytes(b + 9, 2000);
        repeat (3) @(negedge clk);
        check("stall_rd_total", 32'(rd_cnt - rd0), 32'd4);
        check("stall_frame_done", 32'(done_cnt - d0), 32'd1);

        // Abort during the high byte of word 2.
        uart_en = 1'b0;
        repeat (3) @(negedge clk);
        b = nbytes; rd0 = rd_cnt; d0 = done_cnt;
        exp_q.push_back(8'hAA);
        exp_word(14'h1A5A); exp_word(14'h2B6B);
        fq.push_back(14'h1A5A); fq.push_back(14'h2B6B);
        fq.push_back(14'h3C7C); fq.push_back(14'h0D8D);
        repeat (3) @(negedge clk);
        uart_en = 1'b1;
        wait_bytes(b + 3, 2000);
        repeat (10) @(negedge clk);
        uart_en = 1'b0;
        wait_bytes(b + 5, 2000);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (50) @(negedge clk);
        check("abort_bytes", 32'(nbytes - b), 32'd5);
        check("abort_rd_pulses", 32'(rd_cnt - rd0), 32'd2);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        fq.delete();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of byte 3 (all-zero data bits).
        b = nbytes;
        exp_q.push_back(8'hAA);
        exp_word(14'h1200); exp_word(14'h0101); exp_word(14'h0202); exp_word(14'h0303);
        fq.push_back(14'h1200); fq.push_back(14'h0101);
        fq.push_back(14'h0202); fq.push_back(14'h0303);
        repeat (3) @(negedge clk);
        uart_en = 1'b1;
        wait_bytes(b + 2, 2000);
        repeat (15) @(negedge clk);
        check("pre_reset_txd", 32'(uart_txd), 32'd0);
        #2;
        rst_n = 1'b0;
        uart_en = 1'b0;
        #1;
        check("async_rst_txd", 32'(uart_txd), 32'd1);
        check("async_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        fq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_idle_bytes", 32'(nbytes - b), 32'd2);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        full_frame("after_rst", 14'h2AAA, 14'h1555, 14'h0080, 14'h3F00);

        uart_en = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("rd_while_empty", 32'(rd_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
